// File: rtl/sync_mod12_down_counter_pkg.sv
// Shared types and constants for the sync counter family.
// Build option: SYNC_MOD12_DOWN_CASCADE_EN adds cin/bout cascade ports
// to the down counter (see sync_mod12_down_counter.sv).
package sync_counter_pkg;

   // One-shot controller states; periodic mode always sits in IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   localparam int MODULUS_12 = 12;

endpackage

// File: rtl/sync_mod12_down_counter_if.sv
// Bundle of control/status signals for sync_mod12_down_counter.
// Build option: SYNC_MOD12_DOWN_CASCADE_EN adds cin (borrow-in) and
// bout (borrow-out) to the bundle.
//
// Request semantics: en, mode, start and load are level-sampled at every
// rising clk edge; there is no ready/acknowledge. A request that is high
// at an edge is acted on at that edge (priority load > start > count),
// and the result is visible on q/tc/load_err right after the edge.
interface sync_mod12_down_counter_if
   import sync_counter_pkg::*;
#(
   parameter int WIDTH = 4
);
   logic             en;
   logic             mode;
   logic             start;
   logic             load;
   logic [WIDTH-1:0] i;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             load_err;
   logic             busy;
   state_t           dbg_state;
`ifdef SYNC_MOD12_DOWN_CASCADE_EN
   logic             cin;
   logic             bout;

   modport master (
      output en, mode, start, load, i, cin,
      input  q, tc, load_err, busy, dbg_state, bout
   );
   modport slave (
      input  en, mode, start, load, i, cin,
      output q, tc, load_err, busy, dbg_state, bout
   );
`else
   modport master (
      output en, mode, start, load, i,
      input  q, tc, load_err, busy, dbg_state
   );
   modport slave (
      input  en, mode, start, load, i,
      output q, tc, load_err, busy, dbg_state
   );
`endif
endinterface

// File: rtl/sync_mod12_down_counter_mod_n_dec.sv
// Combinational modulo-N decrement: next value and wrap detection.
module mod_n_dec
   import sync_counter_pkg::*;
#(
   parameter int MODULUS = MODULUS_12,
   parameter int WIDTH   = 4
) (
   input  logic [WIDTH-1:0] i_q,
   output logic [WIDTH-1:0] o_q_next,
   output logic             o_wrap
);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   // Zero is the wrap point: the next value folds back to MODULUS-1.
   assign o_wrap   = (i_q == '0);
   assign o_q_next = o_wrap ? MAX_VAL : (i_q - WIDTH'(1));
endmodule

// File: rtl/sync_mod12_down_counter.sv
// Modulo-N down counter with periodic and one-shot modes, range-checked
// parallel load, terminal-count pulse and busy flag.
// Build option: SYNC_MOD12_DOWN_CASCADE_EN adds borrow-in cin (gates the
// count enable) and combinational borrow-out bout for chaining stages.
module sync_mod12_down_counter
   import sync_counter_pkg::*;
#(
   parameter int MODULUS = MODULUS_12,
   parameter int WIDTH   = 4
) (
   input logic                      clk,
   input logic                      rst,
   sync_mod12_down_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   // One extra bit so MODULUS == 2**WIDTH still compares correctly.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic             r_load_err;
   state_t           r_state;

   logic [WIDTH-1:0] w_q_nxt;
   logic             w_tc_nxt;
   logic             w_err_nxt;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] w_dec_q;
   logic             w_wrap;
   logic             w_cnt_en;
   logic             w_load_ok;
   logic             w_load_bad;

`ifdef SYNC_MOD12_DOWN_CASCADE_EN
   assign w_cnt_en = bus.en & bus.cin;
`else
   assign w_cnt_en = bus.en;
`endif

   assign w_load_ok  = bus.load & ({1'b0, bus.i} < MOD_EXT);
   assign w_load_bad = bus.load & ~w_load_ok;

   mod_n_dec #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
   ) u_dec (
      .i_q      (r_q),
      .o_q_next (w_dec_q),
      .o_wrap   (w_wrap)
   );

   // State register: count, pulses and one-shot state; async active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q        <= '0;
         r_tc       <= 1'b0;
         r_load_err <= 1'b0;
         r_state    <= IDLE;
      end else begin
         r_q        <= w_q_nxt;
         r_tc       <= w_tc_nxt;
         r_load_err <= w_err_nxt;
         r_state    <= w_state_nxt;
      end
   end

   // Next-state: valid load > start > count > hold; a rejected load
   // only raises load_err and lets start/count proceed.
   always_comb begin
      w_q_nxt     = r_q;
      w_tc_nxt    = 1'b0;
      w_err_nxt   = w_load_bad;
      w_state_nxt = r_state;
      if (bus.mode == MODE_PERIODIC) begin
         // Periodic mode parks the FSM in IDLE (covers the 1 -> 0 switch).
         w_state_nxt = IDLE;
         if (w_load_ok) begin
            w_q_nxt = bus.i;
         end else if (w_cnt_en) begin
            w_q_nxt  = w_dec_q;
            w_tc_nxt = w_wrap;
         end
      end else begin
         if (w_load_ok) begin
            w_q_nxt     = bus.i;
            w_state_nxt = RUN;
         end else if (bus.start) begin
            w_q_nxt     = MAX_VAL;
            w_state_nxt = RUN;
         end else begin
            case (r_state)
               RUN: begin
                  if (w_cnt_en) begin
                     if (w_wrap) begin
                        // Stop at zero instead of wrapping.
                        w_tc_nxt    = 1'b1;
                        w_state_nxt = DONE;
                     end else begin
                        w_q_nxt = w_dec_q;
                     end
                  end
               end
               IDLE, DONE: begin
                  w_state_nxt = r_state;
               end
               default: begin
                  w_state_nxt = IDLE;
               end
            endcase
         end
      end
   end

   assign bus.q         = r_q;
   assign bus.tc        = r_tc;
   assign bus.load_err  = r_load_err;
   assign bus.dbg_state = r_state;
   // busy is forced low while reset is held.
   assign bus.busy      = rst & ((bus.mode == MODE_PERIODIC) ? bus.en : (r_state == RUN));

`ifdef SYNC_MOD12_DOWN_CASCADE_EN
   // Borrow out when this stage is about to wrap/finish from zero.
   assign bus.bout = bus.en & bus.cin & (r_q == '0) &
                     ((bus.mode == MODE_PERIODIC) | (r_state == RUN));
`endif
endmodule

// File: tb/tb_sync_mod12_down_counter.sv
// Self-checking bench for sync_mod12_down_counter: directed vectors with
// an expected-value queue drained by a monitor one step after each edge.
module tb_sync_mod12_down_counter;
   import sync_counter_pkg::*;

   logic clk;
   logic rst;

   sync_mod12_down_counter_if #(.WIDTH(4)) bus ();

   sync_mod12_down_counter #(.MODULUS(12), .WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef SYNC_MOD12_DOWN_CASCADE_EN
   logic c_en;
   sync_mod12_down_counter_if #(.WIDTH(4)) cbus1 ();
   sync_mod12_down_counter_if #(.WIDTH(4)) cbus2 ();

   sync_mod12_down_counter #(.MODULUS(12), .WIDTH(4)) u_stage1 (
      .clk (clk), .rst (rst), .bus (cbus1)
   );
   sync_mod12_down_counter #(.MODULUS(12), .WIDTH(4)) u_stage2 (
      .clk (clk), .rst (rst), .bus (cbus2)
   );

   assign cbus1.en    = c_en;
   assign cbus1.mode  = MODE_PERIODIC;
   assign cbus1.start = 1'b0;
   assign cbus1.load  = 1'b0;
   assign cbus1.i     = 4'd0;
   assign cbus1.cin   = 1'b1;
   assign cbus2.en    = c_en;
   assign cbus2.mode  = MODE_PERIODIC;
   assign cbus2.start = 1'b0;
   assign cbus2.load  = 1'b0;
   assign cbus2.i     = 4'd0;
   assign cbus2.cin   = cbus1.bout;
`endif

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard state: {q[3:0], tc, load_err, busy}
   logic [6:0] exp_q[$];
   string      name_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   logic [6:0] mon_exp;
   logic [6:0] mon_act;
   string      mon_name;

   // monitor: compares one queued expectation per clock, 1 time unit after the edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         mon_act  = {bus.q, bus.tc, bus.load_err, bus.busy};
         n_cmp++;
         if (mon_act !== mon_exp) begin
            n_err++;
            $display("FAIL %s: got q=%0d tc=%b load_err=%b busy=%b, want q=%0d tc=%b load_err=%b busy=%b",
                     mon_name, mon_act[6:3], mon_act[2], mon_act[1], mon_act[0],
                     mon_exp[6:3], mon_exp[2], mon_exp[1], mon_exp[0]);
         end
      end
   end

   // direct check used outside the clocked stream (reset, cascade)
   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h, want 0x%02h", nm, act, exp);
      end
   endtask

   // driver: apply inputs at negedge, queue the result expected after the next posedge
   task automatic drive(input logic en_v, input logic mode_v, input logic start_v,
                        input logic load_v, input logic [3:0] i_v,
                        input logic [3:0] eq, input logic etc, input logic eerr,
                        input logic ebusy, input string nm);
      @(negedge clk);
      bus.en    = en_v;
      bus.mode  = mode_v;
      bus.start = start_v;
      bus.load  = load_v;
      bus.i     = i_v;
      exp_q.push_back({eq, etc, eerr, ebusy});
      name_q.push_back(nm);
   endtask

   initial begin
      logic [3:0] e;
      rst       = 1'b0;
      bus.en    = 1'b1;
      bus.mode  = MODE_PERIODIC;
      bus.start = 1'b0;
      bus.load  = 1'b0;
      bus.i     = 4'd0;
`ifdef SYNC_MOD12_DOWN_CASCADE_EN
      bus.cin   = 1'b1;
      c_en      = 1'b0;
`endif
      // reset held two cycles with en=1: everything must read zero
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", {1'b0, bus.q, bus.tc, bus.load_err, bus.busy}, 8'h00);
      rst    = 1'b1;
      bus.en = 1'b0;

      // periodic wrap: 0 -> 11 .. 0 -> 11 -> 10, tc on each 11
      for (int k = 1; k <= 14; k++) begin
         e = ((k % 12) == 0) ? 4'd0 : 4'(12 - (k % 12));
         drive(1, 0, 0, 0, 4'd0, e, (e == 4'd11), 0, 1, "periodic");
      end

      // load range checking in periodic mode with en=0
      drive(0, 0, 0, 1, 4'd7,  4'd7, 0, 0, 0, "load_7");
      drive(0, 0, 0, 1, 4'd12, 4'd7, 0, 1, 0, "load_12_rejected");
      drive(0, 0, 0, 1, 4'd15, 4'd7, 0, 1, 0, "load_15_rejected");
      drive(0, 0, 0, 0, 4'd0,  4'd7, 0, 0, 0, "load_err_clears");

      // one-shot: start, count down to 0, tc, then stay DONE
      drive(0, 1, 1, 0, 4'd0, 4'd11, 0, 0, 1, "os_start");
      for (int k = 1; k <= 11; k++)
         drive(1, 1, 0, 0, 4'd0, 4'(11 - k), 0, 0, 1, "os_count");
      drive(1, 1, 0, 0, 4'd0, 4'd0, 1, 0, 0, "os_tc");
      repeat (5) drive(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "os_done_hold");

      // simultaneous events in RUN
      drive(0, 1, 0, 1, 4'd5,  4'd5,  0, 0, 1, "sim_load5_enters_run");
      drive(0, 1, 1, 1, 4'd3,  4'd3,  0, 0, 1, "sim_load_beats_start");
      drive(0, 1, 1, 1, 4'd13, 4'd11, 0, 1, 1, "sim_bad_load_start");
      drive(0, 1, 0, 0, 4'd0,  4'd11, 0, 0, 1, "sim_run_hold");

      // 1 -> 0 mode switch keeps counting from current q
      drive(1, 0, 0, 0, 4'd0, 4'd10, 0, 0, 1, "mode_to_periodic");

      // load 0 in one-shot: RUN at 0, next enabled edge gives tc and DONE
      drive(0, 1, 0, 1, 4'd0, 4'd0, 0, 0, 1, "os_load0");
      drive(1, 1, 0, 0, 4'd0, 4'd0, 1, 0, 0, "os_load0_tc");

      // en gating in periodic mode
      drive(0, 0, 0, 1, 4'd6, 4'd6, 0, 0, 0, "gate_load6");
      repeat (3) drive(0, 0, 0, 0, 4'd0, 4'd6, 0, 0, 0, "gate_hold");
      drive(1, 0, 0, 0, 4'd0, 4'd5, 0, 0, 1, "gate_resume");

      // asynchronous reset while tc is high
      drive(0, 0, 0, 1, 4'd0, 4'd0,  0, 0, 0, "pre_rst_load0");
      drive(1, 0, 0, 0, 4'd0, 4'd11, 1, 0, 1, "pre_rst_wrap");
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("async_reset", {1'b0, bus.q, bus.tc, bus.load_err, bus.busy}, 8'h00);
      @(negedge clk);
      bus.en = 1'b0;
      rst    = 1'b1;

`ifdef SYNC_MOD12_DOWN_CASCADE_EN
      // two chained stages from 0/0: stage 2 steps only on stage 1 wraps
      c_en = 1'b1;
      @(posedge clk); #1;
      check("casc_edge1", {cbus1.q, cbus2.q}, {4'd11, 4'd11});
      @(posedge clk); #1;
      check("casc_edge2", {cbus1.q, cbus2.q}, {4'd10, 4'd11});
      repeat (10) @(posedge clk);
      #1;
      check("casc_edge12", {cbus1.q, cbus2.q}, {4'd0, 4'd11});
      @(posedge clk); #1;
      check("casc_edge13", {cbus1.q, cbus2.q}, {4'd10, 4'd10} | 8'h10);
      repeat (131) @(posedge clk);
      #1;
      check("casc_edge144", {cbus1.q, cbus2.q}, 8'h00);
      c_en = 1'b0;
`endif

      // every queued expectation must have been consumed
      repeat (2) @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // hard time limit
   initial begin
      #200000;
      $display("FAIL timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/sync_mod12_down_counter.md
Name: sync_mod12_down_counter

Overview:
- Synchronous MOD-N down counter with a default modulus of 12. It is the count-down counterpart of the team's mod-12 up counter.
- Supports periodic (free-running wrap) and one-shot (count to zero, then stop) modes.
- Has parallel load with range checking, a terminal-count pulse and a busy flag.
- Used as a reload timer and as a tick divider that feeds the up-counter chain.

Parameters:
- MODULUS, 12, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
- WIDTH, 4, bit width of q and i.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-low reset; asserted when 0.
- en  input  1  count enable; when 0, q holds.
- mode  input  1  0 = periodic, 1 = one-shot.
- start  input  1  one-shot arm; used in mode 1 only.
- load  input  1  parallel load request.
- i  input  WIDTH  load value.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered).
- load_err  output  1  rejected-load pulse (registered).
- busy  output  1  counter actively counting.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-low. While rst=0: q=0, tc=0, load_err=0, state=IDLE, busy=0.
- Priority at each clk edge: valid load > start > count > hold.
- tc and load_err are 1-cycle pulses. Each is cleared on the next edge unless re-triggered.

Load:
- Valid load (load=1, i < MODULUS): q <= i.
  - In mode 1, state <= RUN.
  - In mode 0, state is unchanged.
  - No tc is generated.
- Invalid load (load=1, i >= MODULUS): q and state are unchanged and load_err <= 1.
  - Any start or count in the same cycle proceeds as if load=0.

Mode 0, periodic (state is held at IDLE):
- en=1: q <= (q==0) ? MODULUS-1 : q-1.
  - tc <= 1 exactly on the 0 -> MODULUS-1 wrap edge, so tc is high in the cycle where q = MODULUS-1.
- en=0: q holds and tc=0.
- start is ignored.
- busy = en.

Mode 1, one-shot FSM:
- IDLE:
  - q holds.
  - start=1 -> q <= MODULUS-1, state <= RUN.
  - A valid load also enters RUN.
- RUN:
  - en=1, q>0 -> q <= q-1.
  - en=1, q==0 -> q stays 0, tc <= 1, state <= DONE.
  - en=0 -> hold.
  - start=1 in RUN restarts: q <= MODULUS-1.
- DONE:
  - q holds 0.
  - start=1 -> q <= MODULUS-1, state <= RUN.
  - A valid load also enters RUN.
- busy = (state==RUN).
- Loading 0 in mode 1 gives RUN with q=0. The next enabled edge produces tc and DONE.

Mode change:
- mode is sampled every edge.
- 1 -> 0: state <= IDLE and periodic counting continues from the current q.
- 0 -> 1: state <= IDLE and q holds until start or a valid load.

Reset mid-count: immediate return to reset values, with no tc.

Arithmetic: WIDTH-bit unsigned values. q never holds a value >= MODULUS.

Optional Feature:
- Macro: SYNC_MOD12_DOWN_CASCADE_EN.
- With the macro defined:
  - Adds input cin (1 bit, borrow-in).
  - Effective count enable is en & cin.
  - Adds output bout (1 bit, combinational) = en & cin & (q==0) & counting-allowed, where counting-allowed is mode 0, or mode 1 with state RUN.
  - Stages chain via bout -> next-stage cin.
- Without the macro:
  - Ports cin and bout are absent.
  - Effective count enable is en.

Decomposition:
- Shared package sync_counter_pkg holds:
  - State typedef: IDLE, RUN, DONE.
  - Mode constants MODE_PERIODIC=0 and MODE_ONESHOT=1.
  - Default MODULUS_12=12.
- One natural sub-module, mod_n_dec: combinational next-value and wrap detection (inputs q, MODULUS; outputs q_next, wrap). The FSM, load checking and registers stay in the top module.

Test Plan:
- Reset and periodic wrap: rst=0 for 2 cycles, then rst=1, mode=0, en=1 for 14 cycles -> q = 0, 11, 10, ..., 0, 11, 10; tc high only in the two cycles where q=11 follows 0.
- Load range: mode=0, en=0, load=1, i=7 -> q=7, load_err=0; load=1, i=12 -> q stays 7, load_err=1 for one cycle; i=15 -> same result.
- One-shot: mode=1, start pulse -> q=11, busy=1; en=1 for 12 cycles -> q reaches 0, then tc=1 for one cycle; state DONE, busy=0, q held at 0 for 5 further cycles.
- Simultaneous events: in RUN at q=5, load=1, i=3 with start=1 -> q=3 (load wins); load=1, i=13 with start=1 -> q=11, load_err=1.
- en gating and asynchronous reset: periodic at q=6, en=0 for 3 cycles -> q holds 6; rst driven low mid-cycle -> q=0, tc=0 without waiting for a clk edge.
- Cascade (SYNC_MOD12_DOWN_CASCADE_EN): two stages chained via bout -> cin, both at 0 -> stage 2 decrements only on the edges where stage 1 wraps 0 -> 11; a 144-cycle run returns both stages to 0.
